// File: rtl/cgra_obi_rr_arbiter.sv
// rtl/cgra_obi_rr_arbiter.sv - round-robin OBI arbiter sharing one bus slave port among CGRA masters
`timescale 1ns/1ps
module cgra_obi_rr_arbiter #(
  parameter int NUM_MASTERS     = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_MASTERS-1:0]                m_req_i,
  input  logic [NUM_MASTERS-1:0]                m_we_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_be_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wdata_i,
  output logic [NUM_MASTERS-1:0]                m_gnt_o,
  output logic [NUM_MASTERS-1:0]                m_rvalid_o,
  output logic [DATA_WIDTH-1:0]                 m_rdata_o,
  output logic                                  bus_req_o,
  output logic                                  bus_we_o,
  output logic [DATA_WIDTH/8-1:0]               bus_be_o,
  output logic [ADDR_WIDTH-1:0]                 bus_addr_o,
  output logic [DATA_WIDTH-1:0]                 bus_wdata_o,
  input  logic                                  bus_gnt_i,
  input  logic                                  bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                 bus_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0]      outstanding_o,
  output logic                                  err_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam int BE_W  = DATA_WIDTH / 8;

  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  logic [IDX_W-1:0] w_sel;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  logic             w_full;
  logic             w_empty;
  logic             w_valid;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);

  // First requester at or after the round-robin pointer, wrapping modulo NUM_MASTERS.
  always_comb begin
    w_sel   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      w_idx = IDX_W'((32'(r_rr_ptr) + 32'(k)) % NUM_MASTERS);
      if (!w_found && m_req_i[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_valid = w_found && !w_full;
  assign w_push  = w_valid && bus_gnt_i;
  assign w_pop   = bus_rvalid_i && !w_empty;

  assign bus_req_o   = w_valid;
  assign bus_we_o    = w_valid ? m_we_i[w_sel] : 1'b0;
  assign bus_be_o    = w_valid ? m_be_i[w_sel*BE_W +: BE_W] : '0;
  assign bus_addr_o  = w_valid ? m_addr_i[w_sel*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign bus_wdata_o = w_valid ? m_wdata_i[w_sel*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    if (w_push) m_gnt_o[w_sel] = 1'b1;
    if (w_pop)  m_rvalid_o[r_fifo[r_head]] = 1'b1;
  end

  assign m_rdata_o     = bus_rdata_i;
  assign outstanding_o = r_count;
  assign err_o         = r_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_tail] <= w_sel;
        r_tail         <= r_tail + 1'b1;
        r_rr_ptr       <= (w_sel == IDX_W'(NUM_MASTERS - 1)) ? '0 : w_sel + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A response with nothing outstanding cannot be routed; flag it until reset.
      if (bus_rvalid_i && w_empty) r_err <= 1'b1;
    end
  end

endmodule

// File: doc/cgra_obi_rr_arbiter.md
Name: cgra_obi_rr_arbiter

Overview:
- Shares the single external-bus slave port among the CGRA's master ports (default 8).
- Each master drives an OBI-style request channel. The arbiter selects one requester per cycle by round-robin and forwards it to the bus.
- It records the granted master's index in an in-order FIFO, and routes each response (rvalid/rdata) back to the master at the FIFO head.
- Sits between the CGRA master ports and the external crossbar master input.

Parameters:
- NUM_MASTERS, 8, number of CGRA master ports (>=2).
- MAX_OUTSTANDING, 4, depth of the response-routing FIFO (power of 2, >=2).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte enable is DATA_WIDTH/8.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- m_req_i  in  NUM_MASTERS  per-master request.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_be_i  in  NUM_MASTERS*DATA_WIDTH/8  per-master byte enables, packed, master 0 in the LSBs.
- m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  per-master address, packed.
- m_wdata_i  in  NUM_MASTERS*DATA_WIDTH  per-master write data, packed.
- m_gnt_o  out  NUM_MASTERS  per-master grant, one-hot or zero.
- m_rvalid_o  out  NUM_MASTERS  per-master response valid, one-hot or zero.
- m_rdata_o  out  DATA_WIDTH  response data, broadcast to all masters.
- bus_req_o  out  1  request to the external bus.
- bus_we_o  out  1  write enable to the bus.
- bus_be_o  out  DATA_WIDTH/8  byte enables to the bus.
- bus_addr_o  out  ADDR_WIDTH  address to the bus.
- bus_wdata_o  out  DATA_WIDTH  write data to the bus.
- bus_gnt_i  in  1  bus grant.
- bus_rvalid_i  in  1  bus response valid.
- bus_rdata_i  in  DATA_WIDTH  bus response data.
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy.
- err_o  out  1  sticky protocol error flag.

Behaviour:
- Reset (rst_i=1 at the clock edge):
  - rr_ptr=0, FIFO empty, err_o=0.
  - All registered state is cleared. Any in-flight bus transactions are abandoned; responses arriving after reset are treated as errors.
- Selection (combinational):
  - sel = first index i with m_req_i[i]=1, searching from rr_ptr upward, modulo NUM_MASTERS.
  - valid_sel = (m_req_i != 0) && !fifo_full.
- Bus request:
  - bus_req_o = valid_sel.
  - bus_we/be/addr/wdata_o = fields of master sel.
  - When valid_sel=0, these fields are driven to 0.
- Grant:
  - m_gnt_o[sel] = valid_sel & bus_gnt_i; all other bits are 0.
  - The arbiter adds zero cycles of request latency: bus_req_o and m_gnt_o are combinational paths.
- Handshake (valid_sel & bus_gnt_i, sampled at the clock edge):
  - Push sel into the FIFO.
  - rr_ptr <= (sel+1) mod NUM_MASTERS.
- Without a handshake, rr_ptr holds. A request held with no grant keeps the same selection; this is OBI stability, and the arbiter must not switch away from a pending, ungranted request unless a higher-priority-from-ptr master asserts.
- Fairness: a master that continuously requests is granted within NUM_MASTERS handshakes.
- Response routing (combinational):
  - m_rvalid_o[head] = bus_rvalid_i & !fifo_empty.
  - m_rdata_o = bus_rdata_i.
  - On the clock edge with bus_rvalid_i & !fifo_empty, pop the FIFO.
- Responses are strictly in order. The bus returns rvalid no earlier than 1 cycle after the corresponding gnt.
- Simultaneous push and pop in the same cycle: occupancy unchanged, head and tail both advance.
- Full condition: when occupancy = MAX_OUTSTANDING, bus_req_o=0 and no grants are issued. This holds even if a pop occurs in the same cycle; the next cycle can then issue.
- Error: bus_rvalid_i=1 while the FIFO is empty sets err_o=1 (sticky until reset). No m_rvalid_o bit is asserted and there is no pop.
- outstanding_o equals the registered occupancy, 0..MAX_OUTSTANDING.
- Pointer arithmetic wraps modulo MAX_OUTSTANDING. Full/empty is decided from an extra wrap bit or from the occupancy counter.

Test Plan:
- Reset, then only master 3 requests, with bus_gnt_i=1 and rvalid 1 cycle later. Expect:
  - m_gnt_o=8'h08 in the same cycle as the request.
  - m_rvalid_o=8'h08 on the response.
  - outstanding_o goes 0→1→0.
  - rr_ptr becomes 4.
- All 8 masters request continuously, bus_gnt_i=1 every cycle, rvalid every cycle after a 1-cycle lag. Expect:
  - Grant order 0,1,2,...,7,0.
  - Each rvalid routed to the matching master.
  - Occupancy steady at 1.
- bus_gnt_i held at 0 for 3 cycles while masters 2 and 5 request. Expect:
  - bus_addr_o stays at master 2's address.
  - No m_gnt_o bits asserted.
  - On gnt, master 2 is granted first, then master 5.
- Masters 0 and 1 request, bus_gnt_i=1, no rvalid for 6 cycles. Expect:
  - 4 grants are issued, then bus_req_o=0 with outstanding_o=4.
  - A single rvalid returns the first response to master 0.
  - The next grant is issued in the following cycle.
- bus_rvalid_i pulsed with the FIFO empty. Expect err_o=1, m_rvalid_o=0, err_o persisting until rst_i, and err_o=0 after reset.
- rst_i asserted with 2 transactions outstanding. Expect:
  - outstanding_o=0 and m_rvalid_o=0 on the next cycle.
  - A stale bus_rvalid_i after reset sets err_o.
